// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default width.
package serial_adder_pkg;

   localparam int N_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder; the only arithmetic in the serial datapath.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit pair per cycle, LSB first, result published on completion.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] sum,
   output logic         cout
);

   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   state_e           state_q, state_d;
   logic [N-1:0]     a_sh_q, a_sh_d;
   logic [N-1:0]     b_sh_q, b_sh_d;
   logic [N-1:0]     psum_q, psum_d;
   logic [N-1:0]     sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fa_sum, fa_cout;

   fa_cell u_fa (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      psum_d  = psum_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = cin;
               cnt_d   = '0;
               psum_d  = '0;
               state_d = ADD;
            end
         end
         ADD: begin
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            carry_d = fa_cout;
            psum_d  = {fa_sum, psum_q[N-1:1]};
            // Counter parks on the last index so it never wraps for power-of-two N.
            if (cnt_q == CNT_W'(N - 1)) begin
               sum_d   = {fa_sum, psum_q[N-1:1]};
               cout_d  = fa_cout;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         psum_q  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         psum_q  <= psum_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy = (state_q == ADD);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: N, default 8, operand and sum width in bits (N >= 2).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request to begin an addition, sampled only in IDLE.
REQ-005 a  input  N  operand A, captured on an accepted start.
REQ-006 b  input  N  operand B, captured on an accepted start.
REQ-007 cin  input  1  carry-in, captured on an accepted start.
REQ-008 busy  output  1  high while bits are being processed (state ADD).
REQ-009 done  output  1  one-cycle pulse; sum/cout hold the new result.
REQ-010 sum  output  N  registered result of the last completed addition.
REQ-011 cout  output  1  registered carry-out of the last completed addition.

Function
REQ-012 Three states SHALL exist: IDLE, ADD and DONE.
REQ-013 IDLE with start=1 at a clock edge SHALL:
- load shift registers with a and b;
- load the carry flop with cin;
- clear the bit counter and partial-sum register;
- move to ADD.
REQ-014 IDLE with start=0 SHALL remain in IDLE with all registers unchanged.
REQ-015 Each ADD cycle SHALL process one bit pair, LSB first:
- s = a0 ^ b0 ^ c;
- carry <= a0&b0 | a0&c | b0&c;
- a/b shift right one bit;
- s shifts into the partial-sum MSB;
- counter increments.
REQ-016 On the edge that processes bit N-1, the block SHALL:
- copy the completed partial sum to sum;
- copy the final carry to cout;
- move to DONE.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-018 Latency: with start sampled at edge E0, done SHALL be high in the cycle following edge EN (N edges later), and busy SHALL be high for exactly N cycles.
REQ-019 start SHALL be ignored in ADD and DONE; a new operation SHALL be accepted no earlier than the first IDLE cycle after done.
REQ-020 sum and cout SHALL be stable from the DONE cycle until the next completion, including during a following operation.
REQ-021 Changes on a, b and cin after acceptance SHALL NOT affect the running operation.
REQ-022 The result SHALL equal (a + b + cin) mod 2^(N+1), split as {cout, sum}, for all inputs including all-ones wrap-around.
REQ-023 The bit counter SHALL be $clog2(N) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-024 rst=1 SHALL asynchronously force, regardless of state (including mid-ADD):
- state = IDLE;
- busy = 0, done = 0, sum = 0, cout = 0;
- carry, counter, operand and partial-sum registers = 0.
REQ-025 After rst deasserts, the first start sampled in IDLE SHALL be accepted normally, with no residue of an aborted operation.

Structure
REQ-026 State encodings (IDLE=2'd0, ADD=2'd1, DONE=2'd2) and the default N SHALL live in the shared package serial_adder_pkg.
REQ-027 The per-bit sum/carry logic SHALL be a single combinational sub-module fa_cell (inputs a, b, cin; outputs sum, cout), instantiated once.
REQ-028 The carry flop SHALL be the only feedback path into fa_cell.

Verification
REQ-029 N=8, a=0x00, b=0x00, cin=0 -> done in cycle 8 after start; sum=0x00, cout=0; busy high exactly 8 cycles.
REQ-030 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1 (full wrap-around).
REQ-031 a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1; then a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0; previous result held until the second done.
REQ-032 Pulse start=1 with new operands at cycles 3 and 8 of an ADD and in the DONE cycle -> all ignored; result matches the first operands only; start held high afterwards is accepted on the first IDLE cycle.
REQ-033 Assert rst at cycle 4 of ADD (a=0xFF, b=0xFF) -> busy, done, sum and cout = 0 immediately; after release, a=0x03, b=0x04, cin=0 -> sum=0x07, cout=0.
REQ-034 Randomised check of 1000 operand pairs against a+b+cin -> zero mismatches; done pulse width always 1 cycle.
